send_scheduler: RTL and testbench

- Packet framer and source arbiter in front of the downstream word sender.
- Selects one of two 16-bit word sources: the capture data stream or the test-pattern counter.
- Wraps the source words into packets of header, PKT_LEN data words and checksum.
- Issues one word per downstream request, signalled by a falling edge on ready_in, using the same word_out/ready strobe convention as the existing word sources.

---
 rtl/send_scheduler.sv | 154 +++++++++++++++
 tb/tb_send_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_scheduler.sv
// Packet framer and source arbiter feeding the downstream word sender.
// Emits header, PKT_LEN source words and a checksum, one word per falling edge of ready_in.
module send_scheduler #(
    parameter int unsigned PKT_LEN = 16,
    parameter logic [7:0]  HDR_TAG = 8'hA5
) (
    input  logic        rdclk,
    input  logic        nreset,
    input  logic        en,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [15:0] cap_word,
    input  logic        cap_valid,
    output logic        cap_rd,
    input  logic [15:0] test_word,
    input  logic        test_valid,
    output logic        test_rd,
    input  logic        ready_in,
    output logic [15:0] word_out,
    output logic        ready,
    output logic        busy,
    output logic [7:0]  pkt_seq
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned IDX_W  = 8;

    typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

    state_t              state, state_nx;
    logic                s0, s1, s2;
    logic                pending, pending_nx;
    logic                mode_q, mode_nx;
    logic [WORD_W-1:0]   csum, csum_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    logic [7:0]          seq_nx;
    logic [WORD_W-1:0]   word_nx;
    logic                ready_nx, cap_rd_nx, test_rd_nx;
    logic                req, avail, emit, src_valid;
    logic [WORD_W-1:0]   src_word;

    // Next-state, emission and datapath updates
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        mode_nx    = mode_q;
        csum_nx    = csum;
        idx_nx     = idx;
        seq_nx     = pkt_seq;
        word_nx    = word_out;
        ready_nx   = 1'b0;
        cap_rd_nx  = 1'b0;
        test_rd_nx = 1'b0;
        req        = s2 & ~s1;
        src_valid  = mode_q ? test_valid : cap_valid;
        src_word   = mode_q ? test_word : cap_word;

        case (state)
            HDR, CSUM: avail = 1'b1;
            DATA:      avail = src_valid;
            default:   avail = 1'b0;
        endcase

        // The ~ready term keeps strobes apart and lets the source pop before the next read
        emit       = (req | pending) & avail & ~ready & ~abort;
        pending_nx = (req | pending) & ~emit;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = HDR;
                    mode_nx  = mode;
                    csum_nx  = '0;
                    idx_nx   = '0;
                end
            end
            HDR: begin
                if (emit) begin
                    word_nx  = {HDR_TAG, pkt_seq};
                    ready_nx = 1'b1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (emit) begin
                    word_nx    = src_word;
                    ready_nx   = 1'b1;
                    cap_rd_nx  = ~mode_q;
                    test_rd_nx = mode_q;
                    csum_nx    = csum + src_word;
                    idx_nx     = idx + IDX_W'(1);
                    if (idx == IDX_W'(PKT_LEN - 1)) begin
                        state_nx = CSUM;
                    end
                end
            end
            CSUM: begin
                if (emit) begin
                    word_nx  = csum;
                    ready_nx = 1'b1;
                    seq_nx   = pkt_seq + 8'(1);
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (abort && state != IDLE) begin
            state_nx   = IDLE;
            pending_nx = 1'b0;
        end
    end

    // State and output registers; en=0 freezes everything but the strobes
    always_ff @(posedge rdclk) begin
        if (!nreset) begin
            state    <= IDLE;
            s0       <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            pending  <= 1'b0;
            mode_q   <= 1'b0;
            csum     <= '0;
            idx      <= '0;
            pkt_seq  <= '0;
            word_out <= '0;
            ready    <= 1'b0;
            cap_rd   <= 1'b0;
            test_rd  <= 1'b0;
            busy     <= 1'b0;
        end else if (en) begin
            state    <= state_nx;
            s0       <= ready_in;
            s1       <= s0;
            s2       <= s1;
            pending  <= pending_nx;
            mode_q   <= mode_nx;
            csum     <= csum_nx;
            idx      <= idx_nx;
            pkt_seq  <= seq_nx;
            word_out <= word_nx;
            ready    <= ready_nx;
            cap_rd   <= cap_rd_nx;
            test_rd  <= test_rd_nx;
            busy     <= (state_nx != IDLE);
        end else begin
            ready    <= 1'b0;
            cap_rd   <= 1'b0;
            test_rd  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_send_scheduler.sv
// Self-checking bench for send_scheduler: packet-level scoreboard, FWFT source models,
// table-driven packets, hand-written corner sequences and randomized packets.
module tb_send_scheduler;

    localparam int unsigned PKT_LEN = 4;

    logic        rdclk = 1'b0;
    logic        nreset, en, start, abort, mode, ready_in;
    logic [15:0] cap_word, test_word, word_out;
    logic        cap_valid, test_valid, cap_rd, test_rd, ready, busy;
    logic [7:0]  pkt_seq;

    always #5 rdclk = ~rdclk;

    send_scheduler #(.PKT_LEN(PKT_LEN), .HDR_TAG(8'hA5)) dut (
        .rdclk(rdclk), .nreset(nreset), .en(en), .start(start), .abort(abort),
        .mode(mode), .cap_word(cap_word), .cap_valid(cap_valid), .cap_rd(cap_rd),
        .test_word(test_word), .test_valid(test_valid), .test_rd(test_rd),
        .ready_in(ready_in), .word_out(word_out), .ready(ready), .busy(busy),
        .pkt_seq(pkt_seq)
    );

    // First-word-fall-through source models
    logic [15:0] cmem [0:1023];
    logic [15:0] tmem [0:1023];
    int cwr = 0, crd = 0, twr = 0, trd = 0;
    assign cap_word   = cmem[10'(crd)];
    assign cap_valid  = (crd < cwr);
    assign test_word  = tmem[10'(trd)];
    assign test_valid = (trd < twr);
    always @(posedge rdclk) begin
        if (cap_rd)  crd <= crd + 1;
        if (test_rd) trd <= trd + 1;
    end

    // Scoreboard
    logic [15:0] exp_q[$];
    logic [15:0] pkt_words[$];
    int tests = 0, fails = 0;
    int words_seen = 0, want = 0, cap_pulses = 0, test_pulses = 0;
    int seq_m = 0;
    logic        prev_ready = 1'b0;
    logic [15:0] last_word = '0, hdr_got = '0;

    always @(negedge rdclk) begin
        if (ready) begin
            logic [15:0] e;
            words_seen++;
            last_word = word_out;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL word_unexpected got %h exp none", word_out);
            end else begin
                e = exp_q.pop_front();
                if (word_out !== e) begin
                    fails++;
                    $display("FAIL word[%0d] got %h exp %h", words_seen, word_out, e);
                end
            end
            tests++;
            if (prev_ready) begin
                fails++;
                $display("FAIL ready_consecutive got 1 exp 0");
            end
        end
        if (cap_rd)  cap_pulses++;
        if (test_rd) test_pulses++;
        if ((cap_rd || test_rd) && !ready) begin
            tests++;
            fails++;
            $display("FAIL rd_without_ready got cap=%b test=%b exp ready=1", cap_rd, test_rd);
        end
        prev_ready = ready;
    end

    typedef struct {
        logic        mode;
        logic [63:0] data;
        logic [15:0] csum;
    } vec_t;
    vec_t tbl[3];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge rdclk);
    endtask

    task automatic fall_edge();
        ready_in = 1'b0;
        tick(2);
        ready_in = 1'b1;
        tick(2);
    endtask

    task automatic wait_word(input string name);
        want++;
        for (int i = 0; i < 40 && words_seen < want; i++) tick(1);
        chk(name, 32'(words_seen), 32'(want));
        want = words_seen;
    endtask

    task automatic push_src(input logic m, input logic [15:0] w);
        if (m) begin tmem[10'(twr)] = w; twr++; end
        else   begin cmem[10'(cwr)] = w; cwr++; end
    endtask

    // Expected packet: header with model sequence, data words, 16-bit wrapping sum
    task automatic add_packet(input bit use_fixed, input logic [15:0] fixed_csum);
        int sum = 0;
        exp_q.push_back({8'hA5, 8'(seq_m)});
        foreach (pkt_words[i]) begin
            exp_q.push_back(pkt_words[i]);
            sum = (sum + int'(pkt_words[i])) % 65536;
        end
        exp_q.push_back(use_fixed ? fixed_csum : 16'(sum));
    endtask

    task automatic pulse_start(input logic m);
        mode  = m;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic finish_packet(input string name);
        tick(2);
        chk({name, "_busy"}, 32'(busy), 32'(0));
        seq_m = (seq_m + 1) % 256;
        chk({name, "_seq"}, 32'(pkt_seq), 32'(seq_m));
    endtask

    // Source words already queued; one edge per word, mode toggled after start
    task automatic run_packet(input logic m, input string name);
        pulse_start(m);
        fall_edge();
        wait_word({name, "_hdr"});
        hdr_got = last_word;
        for (int k = 0; k < int'(PKT_LEN) + 1; k++) begin
            mode = 1'($urandom);
            fall_edge();
            wait_word({name, "_word"});
        end
        finish_packet(name);
    endtask

    initial begin
        int c0, t0;
        logic m;
        logic [15:0] w;
        nreset = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; ready_in = 1'b1;

        tbl[0] = '{mode: 1'b1, data: 64'h0001_0203_0405_0607, csum: 16'h0C10};
        tbl[1] = '{mode: 1'b0, data: 64'h1234_1111_0000_8000, csum: 16'hA345};
        tbl[2] = '{mode: 1'b1, data: 64'hFFFF_0001_0002_0003, csum: 16'h0005};

        // 1: reset with random inputs
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom); abort = 1'($urandom); mode = 1'($urandom);
            ready_in = 1'($urandom);
            tick(1);
            chk("reset_outs", {ready, busy, cap_rd, test_rd, pkt_seq, word_out}, 32'd0);
        end
        start = 1'b0; abort = 1'b0; ready_in = 1'b1;
        nreset = 1'b1;
        tick(3);
        chk("post_reset_outs", {ready, busy, cap_rd, test_rd, pkt_seq, word_out}, 32'd0);

        // 2: table-driven packets
        for (int v = 0; v < 3; v++) begin
            pkt_words.delete();
            for (int i = 0; i < 4; i++) begin
                logic [63:0] d;
                d = tbl[v].data;
                w = d[63 - 16*i -: 16];
                pkt_words.push_back(w);
                push_src(tbl[v].mode, w);
            end
            add_packet(1'b1, tbl[v].csum);
            c0 = cap_pulses; t0 = test_pulses;
            run_packet(tbl[v].mode, "tbl");
            chk("tbl_cap_rd", 32'(cap_pulses - c0), tbl[v].mode ? 32'd0 : 32'd4);
            chk("tbl_test_rd", 32'(test_pulses - t0), tbl[v].mode ? 32'd4 : 32'd0);
        end

        // 3: capture source empty at request, data arrives later; checksum wrap
        pkt_words = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        add_packet(1'b1, 16'hFFFC);
        pulse_start(1'b0);
        fall_edge();
        wait_word("t3_hdr");
        fall_edge();
        tick(10);
        chk("t3_no_word", 32'(words_seen), 32'(want));
        push_src(1'b0, 16'hFFFF);
        tick(1);
        chk("t3_ready_cap_rd", {29'd0, ready, cap_rd, test_rd}, 32'b110);
        want++;
        tick(4);
        chk("t3_one_word", 32'(words_seen), 32'(want));
        for (int i = 0; i < 3; i++) push_src(1'b0, 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            fall_edge();
            wait_word("t3_word");
        end
        finish_packet("t3");

        // 4: two requests with no data, then data; en=0 across a falling edge
        pkt_words.delete();
        for (int i = 0; i < 4; i++) pkt_words.push_back(16'($urandom));
        add_packet(1'b0, 16'h0);
        pulse_start(1'b0);
        fall_edge();
        wait_word("t4_hdr");
        fall_edge();
        tick(4);
        fall_edge();
        tick(6);
        chk("t4_no_data", 32'(words_seen), 32'(want));
        c0 = cap_pulses;
        push_src(1'b0, pkt_words[0]);
        push_src(1'b0, pkt_words[1]);
        wait_word("t4_pending_word");
        tick(10);
        chk("t4_single_word", 32'(words_seen), 32'(want));
        chk("t4_single_pop", 32'(cap_pulses - c0), 32'd1);
        en = 1'b0;
        ready_in = 1'b0;
        tick(3);
        ready_in = 1'b1;
        tick(3);
        en = 1'b1;
        tick(10);
        chk("t4_en_off", 32'(words_seen), 32'(want));
        push_src(1'b0, pkt_words[2]);
        push_src(1'b0, pkt_words[3]);
        for (int k = 0; k < 4; k++) begin
            fall_edge();
            wait_word("t4_word");
        end
        finish_packet("t4");

        // 5: abort after two data words
        pkt_words.delete();
        exp_q.push_back({8'hA5, 8'(seq_m)});
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            exp_q.push_back(w);
            push_src(1'b1, w);
        end
        t0 = test_pulses;
        pulse_start(1'b1);
        for (int k = 0; k < 3; k++) begin
            fall_edge();
            wait_word("t5_word");
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_seq_kept", 32'(pkt_seq), 32'(seq_m));
        chk("t5_exp_drained", 32'(exp_q.size()), 32'd0);
        tick(8);
        chk("t5_no_strobe", 32'(words_seen), 32'(want));
        chk("t5_pops", 32'(test_pulses - t0), 32'd2);
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            pkt_words.push_back(w);
            push_src(1'b1, w);
        end
        add_packet(1'b0, 16'h0);
        t0 = seq_m;
        run_packet(1'b1, "t5b");
        chk("t5_hdr_same_seq", 32'(hdr_got), {16'd0, 8'hA5, 8'(t0)});

        // Randomized packets with data arriving before or after each request
        for (int p = 0; p < 20; p++) begin
            m = 1'($urandom);
            pkt_words.delete();
            for (int i = 0; i < 4; i++) pkt_words.push_back(16'($urandom));
            add_packet(1'b0, 16'h0);
            pulse_start(m);
            fall_edge();
            wait_word("rnd_hdr");
            for (int k = 0; k < 4; k++) begin
                mode = 1'($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    push_src(m, pkt_words[k]);
                    fall_edge();
                end else begin
                    fall_edge();
                    tick($urandom_range(0, 5));
                    push_src(m, pkt_words[k]);
                end
                wait_word("rnd_word");
            end
            fall_edge();
            wait_word("rnd_csum");
            finish_packet("rnd");
        end

        // 6: reset mid-packet, then sequence wrap over 257 packets
        exp_q.push_back({8'hA5, 8'(seq_m)});
        pulse_start(1'b1);
        fall_edge();
        wait_word("t6_hdr");
        nreset = 1'b0;
        tick(1);
        nreset = 1'b1;
        chk("t6_reset_seq", 32'(pkt_seq), 32'd0);
        chk("t6_reset_busy", 32'(busy), 32'd0);
        seq_m = 0;
        for (int p = 1; p <= 257; p++) begin
            pkt_words.delete();
            for (int i = 0; i < 4; i++) begin
                w = 16'(p * 4 + i);
                pkt_words.push_back(w);
                push_src(1'b1, w);
            end
            add_packet(1'b0, 16'h0);
            run_packet(1'b1, "wrap");
            if (p == 256) chk("t6_hdr_256", 32'(hdr_got), 32'h0000A5FF);
            if (p == 257) chk("t6_hdr_257", 32'(hdr_got), 32'h0000A500);
        end

        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("t6_abort_wins", 32'(busy), 32'd0);
        tick(3);
        chk("t6_still_idle", 32'(busy), 32'd0);
        chk("t6_no_extra_words", 32'(words_seen), 32'(want));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
